// File: rtl/yantra_alu_host_driver.sv
// Host-side initiator for the Yantra Vedic ALU tile: turns one {A, B, opcode}
// request into the Load A / Load B / Execute / read-lo / read-hi pin sequence.
module yantra_alu_host_driver #(
  parameter int unsigned SETTLE_CYCLES       = 1,
  parameter bit          SKIP_REDUNDANT_LOAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  alu_ui_in,
  output logic [7:0]  alu_uio_in,
  output logic        alu_ena,
  output logic        alu_rst_n,
  input  logic [7:0]  alu_uo_out,
  output logic [2:0]  dbg_state
);

  // Handshakes: a request transfers on a clk edge where req_valid && req_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready. rsp_valid and
  // rsp_result stay stable until that edge.

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    LOAD_A   = 3'd2,
    LOAD_B   = 3'd3,
    EXEC     = 3'd4,
    READ_LO  = 3'd5,
    READ_HI  = 3'd6,
    RESP     = 3'd7
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic        hold_q, hold_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        need_b_q, need_b_d;
  logic [7:0]  cache_a_q, cache_a_d;
  logic [7:0]  cache_b_q, cache_b_d;
  logic        cache_a_vld_q, cache_a_vld_d;
  logic        cache_b_vld_q, cache_b_vld_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  lo_q, lo_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic [7:0]  ui_q, ui_d;
  logic [7:0]  uio_q, uio_d;
  logic        ena_q, ena_d;
  logic        rst_n_q, rst_n_d;

  logic        skip_a, skip_b;

  assign skip_a = SKIP_REDUNDANT_LOAD && cache_a_vld_q && (cache_a_q == req_a);
  assign skip_b = SKIP_REDUNDANT_LOAD && cache_b_vld_q && (cache_b_q == req_b);

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    need_b_d      = need_b_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_a_vld_d = cache_a_vld_q;
    cache_b_vld_d = cache_b_vld_q;
    cnt_d         = cnt_q;
    lo_d          = lo_q;
    rsp_result_d  = rsp_result_q;

    case (state_q)
      RST_HOLD: begin
        // Keep the tile in reset for one more cycle after rst drops.
        if (hold_q) begin
          state_d = IDLE;
          hold_d  = 1'b0;
        end else begin
          hold_d  = 1'b1;
        end
      end
      IDLE: begin
        if (req_valid) begin
          op_d     = req_opcode;
          a_d      = req_a;
          b_d      = req_b;
          need_b_d = !skip_b;
          if (!skip_a)      state_d = LOAD_A;
          else if (!skip_b) state_d = LOAD_B;
          else              state_d = EXEC;
        end
      end
      LOAD_A: begin
        cache_a_d     = a_q;
        cache_a_vld_d = 1'b1;
        state_d       = need_b_q ? LOAD_B : EXEC;
      end
      LOAD_B: begin
        cache_b_d     = b_q;
        cache_b_vld_d = 1'b1;
        state_d       = EXEC;
      end
      EXEC: begin
        cnt_d   = 4'd0;
        state_d = READ_LO;
      end
      READ_LO: begin
        if (cnt_q == SETTLE) begin
          lo_d    = alu_uo_out;
          cnt_d   = 4'd0;
          state_d = READ_HI;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      READ_HI: begin
        if (cnt_q == SETTLE) begin
          rsp_result_d = {alu_uo_out, lo_q};
          cnt_d        = 4'd0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = RST_HOLD;
    endcase

    // Pin and port outputs are decoded from the next state so they register
    // together with it; the opcode rides along because the tile re-latches it.
    ui_d        = 8'h00;
    uio_d       = 8'h00;
    ena_d       = 1'b1;
    rst_n_d     = 1'b1;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    case (state_d)
      RST_HOLD: begin
        ena_d   = 1'b0;
        rst_n_d = 1'b0;
      end
      IDLE:    req_ready_d = 1'b1;
      LOAD_A: begin
        ui_d  = {op_d, 4'b0001};
        uio_d = a_d;
      end
      LOAD_B: begin
        ui_d  = {op_d, 4'b0010};
        uio_d = b_d;
      end
      EXEC:    ui_d = {op_d, 4'b0011};
      READ_LO: ui_d = {op_d, 4'b0000};
      READ_HI: ui_d = {op_d, 4'b0100};
      RESP:    rsp_valid_d = 1'b1;
      default: ui_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST_HOLD;
      hold_q        <= 1'b0;
      op_q          <= 4'd0;
      a_q           <= 8'd0;
      b_q           <= 8'd0;
      need_b_q      <= 1'b0;
      cache_a_q     <= 8'd0;
      cache_b_q     <= 8'd0;
      cache_a_vld_q <= 1'b0;
      cache_b_vld_q <= 1'b0;
      cnt_q         <= 4'd0;
      lo_q          <= 8'd0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 16'd0;
      ui_q          <= 8'd0;
      uio_q         <= 8'd0;
      ena_q         <= 1'b0;
      rst_n_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      need_b_q      <= need_b_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_a_vld_q <= cache_a_vld_d;
      cache_b_vld_q <= cache_b_vld_d;
      cnt_q         <= cnt_d;
      lo_q          <= lo_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      ui_q          <= ui_d;
      uio_q         <= uio_d;
      ena_q         <= ena_d;
      rst_n_q       <= rst_n_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign alu_ui_in  = ui_q;
  assign alu_uio_in = uio_q;
  assign alu_ena    = ena_q;
  assign alu_rst_n  = rst_n_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_yantra_alu_host_driver.sv
// Bench for yantra_alu_host_driver: a behavioural ALU tile on the pins, a table
// of directed transactions, then backpressure and mid-operation reset sequences.
module tb_yantra_alu_host_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = 4'd0;
  logic [7:0]  req_a = 8'd0;
  logic [7:0]  req_b = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [7:0]  alu_ui_in;
  logic [7:0]  alu_uio_in;
  logic        alu_ena;
  logic        alu_rst_n;
  logic [7:0]  alu_uo_out;
  logic [2:0]  dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  // clock / reset
  always #5 clk = ~clk;

  yantra_alu_host_driver #(.SETTLE_CYCLES(1), .SKIP_REDUNDANT_LOAD(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .alu_ui_in  (alu_ui_in),
    .alu_uio_in (alu_uio_in),
    .alu_ena    (alu_ena),
    .alu_rst_n  (alu_rst_n),
    .alu_uo_out (alu_uo_out),
    .dbg_state  (dbg_state)
  );

  // Behavioural tile: loads on cmd 01/10, computes on 11, byte-select on ui[2].
  logic [7:0]  tile_a, tile_b;
  logic [15:0] tile_res;
  always @(posedge clk) begin
    if (!alu_rst_n) begin
      tile_a   <= 8'd0;
      tile_b   <= 8'd0;
      tile_res <= 16'd0;
    end else if (alu_ena) begin
      case (alu_ui_in[1:0])
        2'b01: tile_a <= alu_uio_in;
        2'b10: tile_b <= alu_uio_in;
        2'b11: begin
          case (alu_ui_in[7:4])
            4'd0:    tile_res <= {8'd0, tile_a} + {8'd0, tile_b};
            4'd1:    tile_res <= {8'd0, tile_a} - {8'd0, tile_b};
            4'd2:    tile_res <= {8'd0, tile_a} * {8'd0, tile_b};
            4'd3:    tile_res <= {8'd0, tile_a & tile_b};
            4'd4:    tile_res <= {8'd0, tile_a | tile_b};
            4'd5:    tile_res <= {8'd0, tile_a ^ tile_b};
            default: tile_res <= 16'd0;
          endcase
        end
        default: ;
      endcase
    end
  end
  assign alu_uo_out = alu_ui_in[2] ? tile_res[15:8] : tile_res[7:0];

  // scoreboard: expected results queued per transaction, popped at response
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver: one full transaction, called at #1 after a posedge
  task automatic run_txn(input string name, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int hold, input int exp_lat,
                         input int exp_la, input int exp_lb);
    int w, lat, nla, nlb, pin_err, stab_err;
    logic [15:0] res, exp_res;
    w = 0; lat = 0; nla = 0; nlb = 0; pin_err = 0; stab_err = 0;
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({name, " accept_timeout"}, {31'd0, req_ready}, 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && lat < 40) begin
      if (alu_ui_in[1:0] == 2'b01) begin
        nla++;
        if (alu_uio_in != a) pin_err++;
      end
      if (alu_ui_in[1:0] == 2'b10) begin
        nlb++;
        if (alu_uio_in != b) pin_err++;
      end
      if (dbg_state >= 3'd2 && dbg_state <= 3'd6 && alu_ui_in[7:4] != op) pin_err++;
      if (alu_ui_in[2] != (dbg_state == 3'd6)) pin_err++;
      if (alu_ui_in[3] || req_ready || !alu_ena || !alu_rst_n) pin_err++;
      @(posedge clk); #1; lat++;
    end
    chk({name, " rsp_timeout"}, {31'd0, rsp_valid}, 32'd1);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " load_a_count"}, nla, exp_la);
    chk({name, " load_b_count"}, nlb, exp_lb);
    chk({name, " pin_errors"}, pin_err, 0);
    res = rsp_result;
    exp_res = exp_q.pop_front();
    chk({name, " result"}, {16'd0, res}, {16'd0, exp_res});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_result != res || req_ready) stab_err++;
    end
    if (hold > 0) chk({name, " backpressure_stable"}, stab_err, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, " ready_after_rsp"}, {30'd0, req_ready, rsp_valid}, 32'h2);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    int          lat;
    int          nla;
    int          nlb;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int w;
    vecs[0] = '{"add",     4'd0, 8'd200, 8'd100, 16'h012C, 7, 1, 1};
    vecs[1] = '{"mul",     4'd2, 8'd255, 8'd255, 16'hFE01, 7, 1, 1};
    vecs[2] = '{"sub",     4'd1, 8'd5,   8'd10,  16'hFFFB, 7, 1, 1};
    vecs[3] = '{"xor",     4'd5, 8'h3C,  8'h0F,  16'h0033, 7, 1, 1};
    vecs[4] = '{"or_skip", 4'd4, 8'h3C,  8'h0F,  16'h003F, 5, 0, 0};
    vecs[5] = '{"and_skpa",4'd3, 8'h3C,  8'hAA,  16'h0028, 6, 0, 1};
    vecs[6] = '{"inval",   4'hF, 8'd9,   8'd9,   16'h0000, 7, 1, 1};
    vecs[7] = '{"add_skpa",4'd0, 8'd9,   8'hF7,  16'h0100, 6, 0, 1};

    // reset values while rst is held
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_outputs", {req_ready, rsp_valid, alu_ena, alu_rst_n, rsp_result, alu_ui_in, alu_uio_in},
        32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold", {29'd0, alu_rst_n, alu_ena, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("idle_entry", {24'd0, alu_rst_n, alu_ena, req_ready, rsp_valid, alu_ui_in[3:0]}, 32'hE0);

    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].res);
      run_txn(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 0,
              vecs[i].lat, vecs[i].nla, vecs[i].nlb);
    end

    // backpressure: response held for 10 cycles
    exp_q.push_back(16'hFFFB);
    run_txn("bp_sub", 4'd1, 8'd5, 8'd10, 10, 7, 1, 1);

    // reset during READ_LO on a fully-cached transaction
    req_valid = 1'b1; req_opcode = 4'd0; req_a = 8'd5; req_b = 8'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_skip_to_exec", {29'd0, dbg_state}, 32'd4);
    w = 0;
    while (dbg_state != 3'd5 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("mid_reach_read_lo", {29'd0, dbg_state}, 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_1", {28'd0, alu_rst_n, rsp_valid, req_ready, alu_ena}, 32'd0);
    chk("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_2", {29'd0, alu_rst_n, rsp_valid, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_idle", {29'd0, alu_rst_n, rsp_valid, req_ready}, 32'h5);

    // caches were cleared: same operands load again
    exp_q.push_back(16'h000F);
    run_txn("post_rst_add", 4'd0, 8'd5, 8'd10, 0, 7, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/yantra_alu_host_driver.md
Name: yantra_alu_host_driver

Overview:
- Host-side initiator for the Yantra Vedic ALU tile pin protocol.
- Accepts a transaction (two operands plus opcode) on a valid/ready request port and sequences the tile pins: Load A, Load B, Execute, read low byte, read high byte.
- Returns the 16-bit result on a valid/ready response port.
- Sits between an on-chip controller (or FPGA test harness) and the tile's ui_in/uio_in/uo_out pins.

Parameters:
- SETTLE_CYCLES, 1, extra cycles the output-select is held before uo_out is sampled (pad/IO delay budget); legal range 0..15.
- SKIP_REDUNDANT_LOAD, 1, when 1, skip the Load A / Load B phase if that operand equals the value the tile already holds.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready at a clk edge
- req_opcode  in  4  ALU opcode (0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR)
- req_a  in  8  operand A
- req_b  in  8  operand B
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer ready
- rsp_result  out  16  tile result {high byte, low byte}
- alu_ui_in  out  8  to tile ui_in: [7:4] opcode, [2] byte select, [1:0] command
- alu_uio_in  out  8  to tile uio_in: operand data
- alu_ena  out  1  to tile ena
- alu_rst_n  out  1  to tile rst_n (active low)
- alu_uo_out  in  8  from tile uo_out

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, alu_ui_in=0, alu_uio_in=0, alu_ena=0, alu_rst_n=0, state=RST_HOLD, both operand caches invalid.
- States:
  - RST_HOLD: one cycle after rst deasserts, alu_rst_n stays 0, then goes to IDLE.
  - IDLE: alu_rst_n=1, alu_ena=1, command=00, req_ready=1.
  - LOAD_A: command=01, uio=A, 1 cycle.
  - LOAD_B: command=10, uio=B, 1 cycle.
  - EXEC: command=11, 1 cycle.
  - READ_LO: command=00, sel=0, SETTLE_CYCLES+1 cycles.
  - READ_HI: command=00, sel=1, SETTLE_CYCLES+1 cycles.
  - RESP.
- On accept, IDLE goes to LOAD_A. Cached operands and the opcode are latched at accept. req_ready is 0 outside IDLE.
- alu_ui_in[7:4] holds the latched opcode in every state from LOAD_A through READ_HI, because the tile re-latches the opcode on every enabled edge.
- alu_ui_in[3] is always 0. alu_ui_in[2] is 1 only in READ_HI.
- Skipping: with SKIP_REDUNDANT_LOAD=1, LOAD_A is skipped when the A cache is valid and equal to req_a; LOAD_B likewise for B. Transitions go directly to the next non-skipped state. On the edge leaving LOAD_A/LOAD_B, the cache is updated and marked valid.
- Sampling: the low byte of the result is captured from alu_uo_out on the final edge of READ_LO, the high byte on the final edge of READ_HI. rsp_result is updated on entry to RESP.
- RESP: rsp_valid=1, held stable with rsp_result until rsp_ready. On the handshake edge, the block returns to IDLE (req_ready=1 the next cycle). There is no new accept in the same cycle as the response handshake.
- Latency: accept edge to rsp_valid high = 5 + 2*SETTLE_CYCLES edges with no skips (7 for the default); minus 1 per skipped load.
- Invalid opcodes (6..15) are issued unmodified; the tile returns 0x0000, which is passed through unchanged.
- rst in any state: next cycle is RST_HOLD with all reset values. rsp_valid drops, the in-flight transaction is discarded, caches are invalidated, and the tile is reset via alu_rst_n.
- The block performs no arithmetic; rsp_result is exactly {hi,lo} as sampled.

Test Plan:
- ADD: A=200, B=100, op=0, empty caches -> pin sequence cmd 01/uio C8, 10/64, 11, then sel 0/1. rsp_result=0x012C, rsp_valid 7 edges after accept.
- MUL then SUB: A=255, B=255, op=2 -> 0xFE01. Then A=5, B=10, op=1 -> 0xFFFB, with both loads issued.
- Skip: XOR A=0x3C, B=0x0F, then a repeat with the same operands and op=4 -> second run issues no LOAD_A/LOAD_B pins, rsp 5 edges after accept, results 0x0033 then 0x003F.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_result stable, req_ready=0 throughout; one cycle after the handshake, req_ready=1.
- Reset mid-op: assert rst during READ_LO -> rsp_valid never asserts, alu_rst_n=0 for two cycles, then IDLE. The next request with the previous operands issues both loads (caches cleared).
- Invalid opcode 0xF, A=9, B=9 -> alu_ui_in[7:4]=F during LOAD_A through READ_HI, rsp_result=0x0000.
